// File: rtl/tick_scheduler.sv
// Shared-prescaler tick scheduler: one base-tick prescaler feeds NCH programmable channels.
// Optional `TICK_SCHED_PAUSE_EN adds a `pause` input that freezes the whole timebase.

module tick_channel #(
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bt,
    input  logic          cfg_sel,
    input  logic [PW-1:0] cfg_period,
    input  logic          cfg_mode,
    input  logic          start,
    input  logic          stop,
    output logic          tick,
    output logic          busy
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_d;
    logic [PW-1:0] period, cnt, cnt_d;
    logic          mode, tick_d;
    logic [PW:0]   cnt_inc;
    logic          per_zero, expire;

    // Widened so cnt+1 cannot wrap at the top of the PW range.
    assign cnt_inc  = {1'b0, cnt} + (PW+1)'(1);
    assign per_zero = (period == '0);
    assign expire   = bt && !per_zero && (cnt_inc >= {1'b0, period});
    assign busy     = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (!stop && start && !per_zero) state_d = RUN;
            RUN: begin
                if (stop)                  state_d = IDLE;
                else if (start)            state_d = RUN;
                else if (bt && per_zero)   state_d = IDLE;
                else if (expire && mode)   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt;
        tick_d = 1'b0;
        if (stop || start) begin
            cnt_d = '0;
        end else if (state == RUN && bt) begin
            if (per_zero) begin
                cnt_d = '0;
            end else if (expire) begin
                tick_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_inc[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            tick   <= 1'b0;
            period <= PW'(1);
            mode   <= 1'b0;
        end else begin
            cnt  <= cnt_d;
            tick <= tick_d;
            if (cfg_sel) begin
                period <= cfg_period;
                mode   <= cfg_mode;
            end
        end
    end
endmodule

module tick_scheduler #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BASE_HZ = 1000,
    parameter int NCH     = 4,
    parameter int PW      = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
`ifdef TICK_SCHED_PAUSE_EN
    input  logic                                 pause,
`endif
    input  logic                                 cfg_we,
    input  logic [$clog2(NCH > 1 ? NCH : 2)-1:0] cfg_ch,
    input  logic [PW-1:0]                        cfg_period,
    input  logic                                 cfg_mode,
    input  logic [NCH-1:0]                       start,
    input  logic [NCH-1:0]                       stop,
    output logic                                 base_tick,
    output logic [NCH-1:0]                       tick,
    output logic [NCH-1:0]                       busy
);
    localparam int DIV = CLK_HZ / BASE_HZ;
    localparam int DW  = $clog2(DIV);
    localparam int CHW = $clog2(NCH > 1 ? NCH : 2);

    logic [DW-1:0] pcnt;
    logic          bt_q, hold;

`ifdef TICK_SCHED_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // While held, the pending pulse is frozen with pcnt and delivered on release,
    // so paused time shifts every channel by exactly the pause length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            bt_q <= 1'b0;
        end else if (!hold) begin
            bt_q <= (pcnt == DW'(DIV-1));
            pcnt <= (pcnt == DW'(DIV-1)) ? '0 : pcnt + DW'(1);
        end
    end

    assign base_tick = bt_q && !hold;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tick_channel #(.PW(PW)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .bt         (base_tick),
            .cfg_sel    (cfg_we && (cfg_ch == CHW'(i))),
            .cfg_period (cfg_period),
            .cfg_mode   (cfg_mode),
            .start      (start[i]),
            .stop       (stop[i]),
            .tick       (tick[i]),
            .busy       (busy[i])
        );
    end
endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler at CLK_HZ=100, BASE_HZ=10: vector table, directed corner
// sequences, and randomized traffic against a cycle-level reference model.

module tb_tick_scheduler;
    localparam int DIV = 10;
    localparam int NCH = 4;
    localparam int PW  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_we;
    logic [1:0]     cfg_ch;
    logic [PW-1:0]  cfg_period;
    logic           cfg_mode;
    logic [NCH-1:0] start, stop;
    logic           base_tick;
    logic [NCH-1:0] tick, busy;
`ifdef TICK_SCHED_PAUSE_EN
    logic           pause = 1'b0;
`endif

    tick_scheduler #(.CLK_HZ(100), .BASE_HZ(10), .NCH(NCH), .PW(PW)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef TICK_SCHED_PAUSE_EN
        .pause      (pause),
`endif
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
        .start      (start),
        .stop       (stop),
        .base_tick  (base_tick),
        .tick       (tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int k      = 0;   // rising edges since reset release

    typedef struct {
        int ch;
        int period;
        bit mode;
        int exp_ticks;
        int exp_first;
        bit exp_busy;
    } vec_t;

    vec_t vt[7];

    // reference model state
    int mp[NCH];
    bit mm[NCH];
    bit mr[NCH];
    int me[NCH];
    bit mt[NCH];
    bit mbt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, k);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic idle_inputs();
        cfg_we = 0; cfg_ch = 0; cfg_period = 0; cfg_mode = 0; start = 0; stop = 0;
`ifdef TICK_SCHED_PAUSE_EN
        pause = 0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        k = 0;
        check("reset_state", {23'd0, base_tick, tick, busy}, 32'd0);
    endtask

    // cfg at edge 1, start sampled at edge 2
    task automatic cfg_start(input int ch, input int p, input bit mode);
        cfg_we = 1; cfg_ch = 2'(ch); cfg_period = PW'(p); cfg_mode = mode;
        step();
        cfg_we = 0;
        start[ch] = 1'b1;
        step();
        start = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            mp[i] = 1; mm[i] = 0; mr[i] = 0; me[i] = 0; mt[i] = 0;
        end
        mbt = 0;
    endtask

    task automatic model_edge(input bit we, input int ch, input int p, input bit md,
                              input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
        for (int i = 0; i < NCH; i++) begin
            mt[i] = 0;
            if (sp[i]) begin
                mr[i] = 0; me[i] = 0;
            end else if (st[i]) begin
                if (mr[i] || mp[i] != 0) begin mr[i] = 1; me[i] = 0; end
            end else if (mr[i] && mbt) begin
                if (mp[i] == 0) begin
                    mr[i] = 0; me[i] = 0;
                end else if (me[i] + 1 >= mp[i]) begin
                    mt[i] = 1; me[i] = 0;
                    if (mm[i]) mr[i] = 0;
                end else begin
                    me[i]++;
                end
            end
            if (we && ch == i) begin mp[i] = p; mm[i] = md; end
        end
        mbt = (k % DIV == 0) && (k > 0);
    endtask

    initial begin
        int cnt, first;
        logic [NCH-1:0] others;
        bit seen;

        // ---- table: tick count and first-tick edge over edges 3..101 ----
        vt[0] = '{0,  3, 1'b0, 3,  31, 1'b1};
        vt[1] = '{1,  2, 1'b1, 1,  21, 1'b0};
        vt[2] = '{2,  0, 1'b0, 0,  0,  1'b0};
        vt[3] = '{3,  1, 1'b0, 10, 11, 1'b1};
        vt[4] = '{1,  4, 1'b1, 1,  41, 1'b0};
        vt[5] = '{2, 11, 1'b0, 0,  0,  1'b1};
        vt[6] = '{0,  5, 1'b1, 1,  51, 1'b0};

        for (int v = 0; v < 7; v++) begin
            do_reset();
            cfg_start(vt[v].ch, vt[v].period, vt[v].mode);
            check("vec_busy_rise", 32'(busy[vt[v].ch]), 32'(vt[v].period != 0));
            cnt = 0; first = 0; others = 0;
            while (k < 101) begin
                step();
                if (tick[vt[v].ch]) begin
                    cnt++;
                    if (first == 0) first = k;
                    if (vt[v].mode) check("vec_oneshot_busy_drop", 32'(busy[vt[v].ch]), 32'd0);
                end
                for (int i = 0; i < NCH; i++) if (i != vt[v].ch) others[i] |= tick[i];
            end
            check("vec_tick_count", cnt, vt[v].exp_ticks);
            check("vec_first_tick", first, vt[v].exp_first);
            check("vec_busy_end", 32'(busy[vt[v].ch]), 32'(vt[v].exp_busy));
            check("vec_other_ticks", 32'(others), 32'd0);
        end

        // ---- base_tick cadence ----
        do_reset();
        cnt = 0; first = 0;
        while (k < 100) begin
            step();
            if (base_tick) begin
                cnt++;
                if (k % DIV != 0) first++;
            end
        end
        check("base_tick_count", cnt, 10);
        check("base_tick_phase", first, 0);

        // ---- stop / restart exactly at expiry ----
        do_reset();
        cfg_start(0, 3, 0);
        cnt = 0;
        while (k < 90) begin step(); cnt += int'(tick[0]); end
        check("pre_stop_ticks", cnt, 2);
        stop[0] = 1;
        step();
        stop = 0;
        check("stop_at_expiry_tick", 32'(tick[0]), 32'd0);
        check("stop_at_expiry_busy", 32'(busy[0]), 32'd0);
        start[0] = 1;
        step();
        start = 0;
        check("restart_busy", 32'(busy[0]), 32'd1);
        cnt = 0;
        while (k < 120) begin step(); cnt += int'(tick[0]); end
        step();
        check("restart_first_tick", {cnt[30:0], tick[0]}, 32'd1);
        cnt = 0;
        while (k < 150) begin step(); cnt += int'(tick[0]); end
        start[0] = 1;
        step();
        start = 0;
        check("restart_at_expiry_tick", {cnt[30:0], tick[0]}, 32'd0);
        check("restart_at_expiry_busy", 32'(busy[0]), 32'd1);
        cnt = 0;
        while (k < 180) begin step(); cnt += int'(tick[0]); end
        step();
        check("restart_next_tick", {cnt[30:0], tick[0]}, 32'd1);

        // ---- shortened period on a running channel ----
        do_reset();
        cfg_start(3, 10, 0);
        cnt = 0;
        while (k < 61) begin step(); cnt += int'(tick[3]); end
        cfg_we = 1; cfg_ch = 2'd3; cfg_period = PW'(4); cfg_mode = 0;
        step();
        cfg_we = 0;
        while (k < 70) begin step(); cnt += int'(tick[3]); end
        check("shorten_no_early_tick", cnt, 0);
        step();
        check("shorten_tick", {tick[3], busy[3]}, 32'b11);

        // ---- asynchronous reset with a tick pending ----
        do_reset();
        cfg_start(0, 3, 0);
        while (k < 30) step();
        check("pre_rst_base_tick", 32'(base_tick), 32'd1);
        rst = 1;
        #1;
        check("async_rst_outputs", {23'd0, base_tick, tick, busy}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        k = 0;
        cnt = 0;
        while (k < 50) begin step(); cnt += int'(|tick) + int'(|busy); end
        check("post_rst_quiet", cnt, 0);
        start[0] = 1;
        step();
        start = 0;
        cnt = 0; first = 0;
        while (k < 80) begin
            step();
            if (tick[0]) begin cnt++; if (first == 0) first = k; end
        end
        check("default_period_ticks", cnt, 2);
        check("default_period_first", first, 61);

`ifdef TICK_SCHED_PAUSE_EN
        // ---- pause shifts the schedule by exactly its length ----
        do_reset();
        cfg_start(0, 3, 0);
        while (k < 15) step();
        pause = 1;
        seen = 0;
        repeat (25) begin step(); seen |= base_tick | tick[0]; end
        pause = 0;
        check("pause_no_base_tick", 32'(seen), 32'd0);
        cnt = 0;
        while (k < 55) begin step(); cnt += int'(tick[0]); end
        check("pause_no_early_tick", cnt, 0);
        step();
        check("pause_delayed_tick", 32'(tick[0]), 32'd1);
`endif

        // ---- randomized traffic against the reference model ----
        do_reset();
        model_reset();
        cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            bit we, md;
            int ch, p;
            logic [NCH-1:0] st, sp;
            we = ($urandom_range(0, 7) == 0);
            ch = $urandom_range(0, NCH-1);
            p  = $urandom_range(0, 4);
            md = 1'($urandom_range(0, 1));
            for (int i = 0; i < NCH; i++) begin
                st[i] = ($urandom_range(0, 15) == 0);
                sp[i] = ($urandom_range(0, 31) == 0);
            end
            cfg_we = we; cfg_ch = 2'(ch); cfg_period = PW'(p); cfg_mode = md;
            start = st; stop = sp;
            step();
            model_edge(we, ch, p, md, st, sp);
            if ({base_tick, tick, busy} !== {mbt, mt[3], mt[2], mt[1], mt[0],
                                            mr[3], mr[2], mr[1], mr[0]}) cnt++;
        end
        idle_inputs();
        check("random_vs_model_mismatched_cycles", cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Shared-timebase scheduler for the 2048 game's timed events: tile-slide animation steps, score blink and key auto-repeat. One free-running prescaler derives a base tick from the system clock. NCH independent channels count base ticks against per-channel programmable periods and emit single-cycle enable pulses. This replaces separate per-feature divider/toggle counters: consumers run on `clk` and qualify on `tick[i]` instead of using divided clocks.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency
- `BASE_HZ`, 1000, base tick rate; `DIV = CLK_HZ/BASE_HZ` (integer, ≥2)
- `NCH`, 4, number of channels (1..8)
- `PW`, 16, period register width in base ticks
---
- `clk` in 1 system clock; all logic on rising edge
- `rst` in 1 asynchronous, active-high reset
- `cfg_we` in 1 write period/mode of channel `cfg_ch`
- `cfg_ch` in $clog2(NCH) target channel; out-of-range ignored
- `cfg_period` in PW period in base ticks
- `cfg_mode` in 1 0 = periodic, 1 = one-shot
- `start` in NCH per-channel start/restart request, level sampled each clk
- `stop` in NCH per-channel stop request
- `base_tick` out 1 one-cycle pulse at BASE_HZ
- `tick` out NCH one-cycle channel expiry pulses
- `busy` out NCH channel is in RUN

## Operation
- Prescaler: `pcnt` counts 0..DIV-1 and wraps to 0. It always runs and is never affected by channel activity. `base_tick` is registered and high for the cycle after `pcnt` == DIV-1.
- Per-channel registers: `period` (reset 1), `mode` (reset 0) and `cnt` (PW bits, reset 0).
- Per-channel FSM states: IDLE, RUN.
  - IDLE → RUN on `start[i]` when `period` ≠ 0. This clears `cnt`. A start with `period` = 0 is ignored.
  - RUN + `start[i]` restarts: `cnt` ← 0 and no tick that cycle.
  - RUN + `stop[i]` → IDLE with `cnt` ← 0.
  - RUN + `base_tick`:
    - If `cnt + 1 >= period`: set `tick[i]`, `cnt` ← 0. A periodic channel stays in RUN; a one-shot channel → IDLE.
    - Otherwise `cnt` ← `cnt + 1`.
- Priority per channel per cycle: stop > start > expiry/count.
- Config write:
  - Updates `period`/`mode` the next cycle.
  - A running channel keeps `cnt`; the `>=` compare makes a shortened period expire at the next base tick.
  - Writing `period` = 0 to a running channel stops it at its next base tick, with no tick.
  - cfg and start on the same channel in the same cycle: the start uses the old period.
- Channels are fully independent. Several ticks may assert in the same cycle.

## Timing
- Reset values: `base_tick` = 0, `tick` = 0, `busy` = 0, `pcnt` = 0, all channels IDLE.
- `busy[i]` rises the cycle after `start[i]`. It falls the cycle after `stop[i]`, or in the same cycle `tick[i]` is high for a one-shot.
- `tick[i]` is registered and high exactly 1 cycle: the cycle after the `base_tick` that satisfies expiry.
- Start-to-first-tick latency:
  - Lower bound: (period-1)·DIV + 2 cycles.
  - Upper bound: period·DIV + 1 cycles.
  - The exact value depends on prescaler phase.
- Periodic ticks are then exactly period·DIV cycles apart.
- `rst` mid-operation forces all outputs to 0 immediately (asynchronously). The period and mode registers return to their reset values. Channels need a fresh `start` after reset.

## Configuration
- `TICK_SCHED_PAUSE_EN` defined:
  - Adds input `pause` (1 bit).
  - While `pause` = 1, `pcnt` holds, `base_tick` = 0, and channel counts freeze.
  - FSM state, start, stop and cfg still act.
  - On release, counting resumes from the frozen values, so pause time never counts.
- Undefined: no `pause` port; the prescaler always runs.

## Test plan
Bench parameters: CLK_HZ=100, BASE_HZ=10 (DIV=10), NCH=4, PW=16.
- Reset, cfg ch0 period=3 periodic, pulse `start[0]` → `busy[0]` next cycle; first `tick[0]` within 22..31 cycles; next ticks every 30 cycles; `base_tick` every 10 cycles.
- cfg ch1 period=2 one-shot, start → exactly one `tick[1]`; `busy[1]` = 0 in that cycle; no further ticks over 100 cycles.
- ch0 running, period=3: assert `stop[0]` in the cycle expiry would register → no `tick[0]`, `busy[0]` = 0; same test with `start[0]` instead → no tick, next tick 30 cycles later.
- cfg ch2 period=0, start → `busy[2]` stays 0. ch3 running period=10 with `cnt`=6: write period=4 → `tick[3]` after the next `base_tick`.
- Assert `rst` mid-run with `tick` pending → all outputs 0 immediately; after release, no ticks until restart; `period` reads back as 1 (one tick per base tick).
- With `TICK_SCHED_PAUSE_EN`: pause 25 cycles mid-period → tick delayed by exactly 25 cycles; no `base_tick` during pause.
